// File: rtl/wvb_rd_ctrl.sv
// Waveform buffer read controller: pops one header per event and streams the event's BRAM
// samples over valid/ready. Define WVB_RD_HDR_WORDS_EN to prepend 4 header words per event.
module wvb_rd_ctrl #(
  parameter int unsigned P_DATA_WIDTH = 22,
  parameter int unsigned P_ADR_WIDTH  = 12,
  parameter int unsigned P_HDR_WIDTH  = 80,
  parameter int unsigned P_LTC_WIDTH  = 48
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rd_en,
  input  logic                    hdr_empty,
  input  logic [P_HDR_WIDTH-1:0]  hdr_data,
  output logic                    hdr_rdreq,
  output logic [P_ADR_WIDTH-1:0]  wvb_rd_addr,
  input  logic [P_DATA_WIDTH-1:0] wvb_data,
  output logic [P_DATA_WIDTH-1:0] dout_data,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    dout_last,
  output logic [P_LTC_WIDTH-1:0]  evt_ltc,
  output logic [P_ADR_WIDTH-1:0]  evt_start,
  output logic [P_ADR_WIDTH-1:0]  evt_stop,
  output logic [1:0]              evt_trig_src,
  output logic                    evt_cnst_run,
  output logic [4:0]              evt_pre_conf,
  output logic [P_ADR_WIDTH:0]    evt_len,
  output logic                    evt_done,
  output logic [P_ADR_WIDTH-1:0]  wvb_rd_ptr
);

  localparam int unsigned L_LEN_W     = P_ADR_WIDTH + 1;
  localparam int unsigned L_STOP_LSB  = 8;
  localparam int unsigned L_START_LSB = 8 + P_ADR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
`ifdef WVB_RD_HDR_WORDS_EN
    S_HDR,
`endif
    S_RD,
    S_DONE
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic                    r_hdr_rdreq, w_hdr_rdreq_nxt;
  logic [P_ADR_WIDTH-1:0]  r_addr, w_addr_nxt;
  logic [L_LEN_W-1:0]      r_rd_left, w_rd_left_nxt;
  logic                    r_inflight, w_inflight_nxt;
  logic                    r_inflight_last, w_inflight_last_nxt;
  logic [P_DATA_WIDTH-1:0] r_sd0, r_sd1, w_sd0_nxt, w_sd1_nxt;
  logic                    r_sl0, r_sl1, w_sl0_nxt, w_sl1_nxt;
  logic [1:0]              r_cnt, w_cnt_nxt;
  logic                    r_vld, w_vld_nxt;
  logic [P_LTC_WIDTH-1:0]  r_ltc, w_ltc_nxt;
  logic [P_ADR_WIDTH-1:0]  r_start, w_start_nxt;
  logic [P_ADR_WIDTH-1:0]  r_stop, w_stop_nxt;
  logic [1:0]              r_trig, w_trig_nxt;
  logic                    r_cnst, w_cnst_nxt;
  logic [4:0]              r_pre, w_pre_nxt;
  logic [L_LEN_W-1:0]      r_len, w_len_nxt;
  logic                    r_done, w_done_nxt;
  logic [P_ADR_WIDTH-1:0]  r_rd_ptr, w_rd_ptr_nxt;

  logic                    w_pop, w_push, w_push_last, w_issue;
  logic [1:0]              w_cnt_pop;
  logic [P_DATA_WIDTH-1:0] w_push_data;
  logic [P_ADR_WIDTH-1:0]  w_hdr_start, w_hdr_stop;
  logic [L_LEN_W-1:0]      w_hdr_len;

  assign w_hdr_start = hdr_data[L_START_LSB +: P_ADR_WIDTH];
  assign w_hdr_stop  = hdr_data[L_STOP_LSB +: P_ADR_WIDTH];
  // Modular difference gives the full-buffer length when stop == start-1
  assign w_hdr_len   = {1'b0, w_hdr_stop - w_hdr_start} + L_LEN_W'(1);

`ifdef WVB_RD_HDR_WORDS_EN
  logic [1:0]              r_hw_idx, w_hw_idx_nxt;
  logic [P_HDR_WIDTH-1:0]  w_hdr_cat;
  logic [P_DATA_WIDTH-1:0] w_hdr_word;

  assign w_hdr_cat = {r_ltc, r_start, r_stop, r_trig, r_cnst, r_pre};

  always_comb begin
    w_hdr_word = '0;
    case (r_hw_idx)
      2'd0:    w_hdr_word = P_DATA_WIDTH'(w_hdr_cat[79:58]);
      2'd1:    w_hdr_word = P_DATA_WIDTH'(w_hdr_cat[57:36]);
      2'd2:    w_hdr_word = P_DATA_WIDTH'(w_hdr_cat[35:14]);
      default: w_hdr_word = P_DATA_WIDTH'(w_hdr_cat[13:0]);
    endcase
  end
`endif

  // Next-state, read issue and skid buffer bookkeeping
  always_comb begin
    w_state_nxt         = r_state;
    w_hdr_rdreq_nxt     = 1'b0;
    w_addr_nxt          = r_addr;
    w_rd_left_nxt       = r_rd_left;
    w_sd0_nxt           = r_sd0;
    w_sd1_nxt           = r_sd1;
    w_sl0_nxt           = r_sl0;
    w_sl1_nxt           = r_sl1;
    w_ltc_nxt           = r_ltc;
    w_start_nxt         = r_start;
    w_stop_nxt          = r_stop;
    w_trig_nxt          = r_trig;
    w_cnst_nxt          = r_cnst;
    w_pre_nxt           = r_pre;
    w_len_nxt           = r_len;
    w_done_nxt          = 1'b0;
    w_rd_ptr_nxt        = r_rd_ptr;
`ifdef WVB_RD_HDR_WORDS_EN
    w_hw_idx_nxt        = r_hw_idx;
`endif
    w_pop               = r_vld & dout_ready;
    w_cnt_pop           = r_cnt - 2'(w_pop);
    w_push              = r_inflight;
    w_push_data         = wvb_data;
    w_push_last         = r_inflight_last;
    w_issue             = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (rd_en && !hdr_empty) begin
          w_hdr_rdreq_nxt = 1'b1;
          w_ltc_nxt       = hdr_data[P_HDR_WIDTH-1 -: P_LTC_WIDTH];
          w_start_nxt     = w_hdr_start;
          w_stop_nxt      = w_hdr_stop;
          w_trig_nxt      = hdr_data[7:6];
          w_cnst_nxt      = hdr_data[5];
          w_pre_nxt       = hdr_data[4:0];
          w_len_nxt       = w_hdr_len;
          w_addr_nxt      = w_hdr_start;
          w_rd_left_nxt   = w_hdr_len;
`ifdef WVB_RD_HDR_WORDS_EN
          w_hw_idx_nxt    = 2'd0;
          w_state_nxt     = S_HDR;
`else
          w_state_nxt     = S_RD;
`endif
        end
      end
`ifdef WVB_RD_HDR_WORDS_EN
      S_HDR: begin
        if (w_cnt_pop != 2'd2) begin
          w_push       = 1'b1;
          w_push_data  = w_hdr_word;
          w_push_last  = 1'b0;
          w_hw_idx_nxt = r_hw_idx + 2'd1;
          if (r_hw_idx == 2'd3) w_state_nxt = S_RD;
        end
      end
`endif
      S_RD: begin
        // Credit check counts the slot freed by this cycle's pop
        if ((r_rd_left != '0) && ((2'(r_inflight) + w_cnt_pop) < 2'd2)) begin
          w_issue       = 1'b1;
          w_addr_nxt    = r_addr + P_ADR_WIDTH'(1);
          w_rd_left_nxt = r_rd_left - L_LEN_W'(1);
        end
        if (w_pop && r_sl0) begin
          w_state_nxt  = S_DONE;
          w_done_nxt   = 1'b1;
          w_rd_ptr_nxt = r_stop + P_ADR_WIDTH'(1);
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_pop) begin
      w_sd0_nxt = r_sd1;
      w_sl0_nxt = r_sl1;
    end
    if (w_push) begin
      if (w_cnt_pop == 2'd0) begin
        w_sd0_nxt = w_push_data;
        w_sl0_nxt = w_push_last;
      end else begin
        w_sd1_nxt = w_push_data;
        w_sl1_nxt = w_push_last;
      end
    end
    w_cnt_nxt           = w_cnt_pop + 2'(w_push);
    w_vld_nxt           = (w_cnt_nxt != 2'd0);
    w_inflight_nxt      = w_issue;
    w_inflight_last_nxt = w_issue && (r_rd_left == L_LEN_W'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_hdr_rdreq     <= 1'b0;
      r_addr          <= '0;
      r_rd_left       <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_sd0           <= '0;
      r_sd1           <= '0;
      r_sl0           <= 1'b0;
      r_sl1           <= 1'b0;
      r_cnt           <= 2'd0;
      r_vld           <= 1'b0;
      r_ltc           <= '0;
      r_start         <= '0;
      r_stop          <= '0;
      r_trig          <= 2'd0;
      r_cnst          <= 1'b0;
      r_pre           <= 5'd0;
      r_len           <= '0;
      r_done          <= 1'b0;
      r_rd_ptr        <= '0;
`ifdef WVB_RD_HDR_WORDS_EN
      r_hw_idx        <= 2'd0;
`endif
    end else begin
      r_state         <= w_state_nxt;
      r_hdr_rdreq     <= w_hdr_rdreq_nxt;
      r_addr          <= w_addr_nxt;
      r_rd_left       <= w_rd_left_nxt;
      r_inflight      <= w_inflight_nxt;
      r_inflight_last <= w_inflight_last_nxt;
      r_sd0           <= w_sd0_nxt;
      r_sd1           <= w_sd1_nxt;
      r_sl0           <= w_sl0_nxt;
      r_sl1           <= w_sl1_nxt;
      r_cnt           <= w_cnt_nxt;
      r_vld           <= w_vld_nxt;
      r_ltc           <= w_ltc_nxt;
      r_start         <= w_start_nxt;
      r_stop          <= w_stop_nxt;
      r_trig          <= w_trig_nxt;
      r_cnst          <= w_cnst_nxt;
      r_pre           <= w_pre_nxt;
      r_len           <= w_len_nxt;
      r_done          <= w_done_nxt;
      r_rd_ptr        <= w_rd_ptr_nxt;
`ifdef WVB_RD_HDR_WORDS_EN
      r_hw_idx        <= w_hw_idx_nxt;
`endif
    end
  end

  assign hdr_rdreq    = r_hdr_rdreq;
  assign wvb_rd_addr  = r_addr;
  assign dout_data    = r_sd0;
  assign dout_valid   = r_vld;
  assign dout_last    = r_sl0;
  assign evt_ltc      = r_ltc;
  assign evt_start    = r_start;
  assign evt_stop     = r_stop;
  assign evt_trig_src = r_trig;
  assign evt_cnst_run = r_cnst;
  assign evt_pre_conf = r_pre;
  assign evt_len      = r_len;
  assign evt_done     = r_done;
  assign wvb_rd_ptr   = r_rd_ptr;

endmodule

// File: tb/tb_wvb_rd_ctrl.sv
// Self-checking bench for wvb_rd_ctrl: header FIFO and BRAM models, queue-based stream scoreboard.
module tb_wvb_rd_ctrl;
  localparam int unsigned DW    = 22;
  localparam int unsigned AW    = 12;
  localparam int unsigned HW    = 80;
  localparam int unsigned LW    = 48;
  localparam int          DEPTH = 1 << AW;
`ifdef WVB_RD_HDR_WORDS_EN
  localparam int          HDRW  = 4;
`else
  localparam int          HDRW  = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rd_en = 1'b0;
  logic          hdr_empty = 1'b1;
  logic [HW-1:0] hdr_data = '0;
  logic          hdr_rdreq;
  logic [AW-1:0] wvb_rd_addr;
  logic [DW-1:0] wvb_data = '0;
  logic [DW-1:0] dout_data;
  logic          dout_valid;
  logic          dout_ready = 1'b1;
  logic          dout_last;
  logic [LW-1:0] evt_ltc;
  logic [AW-1:0] evt_start, evt_stop, wvb_rd_ptr;
  logic [1:0]    evt_trig_src;
  logic          evt_cnst_run, evt_done;
  logic [4:0]    evt_pre_conf;
  logic [AW:0]   evt_len;

  wvb_rd_ctrl dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .hdr_empty(hdr_empty), .hdr_data(hdr_data),
    .hdr_rdreq(hdr_rdreq), .wvb_rd_addr(wvb_rd_addr), .wvb_data(wvb_data),
    .dout_data(dout_data), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_last(dout_last), .evt_ltc(evt_ltc), .evt_start(evt_start), .evt_stop(evt_stop),
    .evt_trig_src(evt_trig_src), .evt_cnst_run(evt_cnst_run), .evt_pre_conf(evt_pre_conf),
    .evt_len(evt_len), .evt_done(evt_done), .wvb_rd_ptr(wvb_rd_ptr)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [DW-1:0] data; logic last; } word_t;
  typedef struct packed { logic [HW-1:0] hdr; logic [AW:0] len; logic [AW-1:0] ptr; } evt_t;
  typedef struct {
    logic [AW-1:0] start;
    logic [AW-1:0] stop;
    int            exp_len;
    logic [AW-1:0] exp_ptr;
    int            mode;
  } vec_t;

  logic [DW-1:0] mem [DEPTH];
  logic [HW-1:0] hq[$];
  word_t         exp_q[$];
  evt_t          exp_evt[$];
  int            n_checks = 0, n_errors = 0;
  int            done_count = 0, rdreq_count = 0, acc_count = 0;
  int            ready_mode = 0;
  logic          busy = 1'b0, pop_pend = 1'b0, stall_pend = 1'b0, stall_last;
  logic [DW-1:0] stall_data;
  logic [31:0]   rnd;
  logic [255:0]  outs;

  assign outs = 256'({hdr_rdreq, wvb_rd_addr, dout_data, dout_valid, dout_last, evt_ltc,
                      evt_start, evt_stop, evt_trig_src, evt_cnst_run, evt_pre_conf,
                      evt_len, evt_done, wvb_rd_ptr});

  // Waveform BRAM: unique contents per address, one-cycle read latency
  initial for (int a = 0; a < DEPTH; a++) begin
    rnd = $urandom;
    mem[a] = {rnd[9:0], 12'(a)};
  end
  always @(posedge clk) wvb_data <= mem[wvb_rd_addr];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [HW-1:0] mk_hdr(input logic [AW-1:0] s, input logic [AW-1:0] e);
    logic [63:0] r;
    r = {$urandom, $urandom};
    return {r[47:0], s, e, r[55:48]};
  endfunction

  // Reference model: expected words and event summary derived from the header alone
  task automatic model_event(input logic [HW-1:0] h);
    int s, e, len;
    word_t w;
    evt_t  ev;
    s   = int'(h[31:20]);
    e   = int'(h[19:8]);
    len = ((e - s + DEPTH) % DEPTH) + 1;
    if (HDRW != 0) begin
      w.last = 1'b0;
      w.data = h[79:58];          exp_q.push_back(w);
      w.data = h[57:36];          exp_q.push_back(w);
      w.data = h[35:14];          exp_q.push_back(w);
      w.data = {8'b0, h[13:0]};   exp_q.push_back(w);
    end
    for (int i = 0; i < len; i++) begin
      w.data = mem[(s + i) % DEPTH];
      w.last = (i == len - 1);
      exp_q.push_back(w);
    end
    ev.hdr = h;
    ev.len = (AW+1)'(len);
    ev.ptr = AW'((e + 1) % DEPTH);
    exp_evt.push_back(ev);
  endtask

  // Header FIFO (show-ahead) and ready driver
  initial forever begin
    @(negedge clk);
    pop_pend = hdr_rdreq && !rst;
    @(posedge clk);
    #1;
    if (pop_pend && hq.size() != 0) begin
      model_event(hq[0]);
      void'(hq.pop_front());
    end
    hdr_empty = (hq.size() == 0);
    hdr_data  = (hq.size() == 0) ? '0 : hq[0];
    dout_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
  end

  // Stream monitor: handshake stability, scoreboard, pop spacing, event summary
  initial forever begin
    @(negedge clk);
    if (rst) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend)
        chk("stall_hold", {dout_valid, dout_data, dout_last}, {1'b1, stall_data, stall_last});
      stall_pend = dout_valid && !dout_ready;
      stall_data = dout_data;
      stall_last = dout_last;
      if (hdr_rdreq) begin
        chk("rdreq_gap_or_empty", {busy, hdr_empty}, 2'b00);
        busy = 1'b1;
        rdreq_count++;
      end
      if (dout_valid && dout_ready) begin
        acc_count++;
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 256'(dout_data), 256'(0) - 1);
        end else begin
          word_t w;
          w = exp_q.pop_front();
          chk("word", {dout_data, dout_last}, {w.data, w.last});
        end
      end
      if (evt_done) begin
        done_count++;
        busy = 1'b0;
        if (exp_evt.size() == 0) begin
          chk("unexpected_done", 256'(evt_done), 256'(0));
        end else begin
          evt_t ev;
          ev = exp_evt.pop_front();
          chk("evt_summary",
              {evt_ltc, evt_start, evt_stop, evt_trig_src, evt_cnst_run, evt_pre_conf,
               evt_len, wvb_rd_ptr},
              {ev.hdr, ev.len, ev.ptr});
          chk("words_left_at_done", 256'(exp_q.size()), 256'(0));
        end
      end
    end
  end

  task automatic wait_done(input int target, input int bound);
    int cyc = 0;
    while (done_count < target && cyc < bound) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_timeout", 256'(done_count >= target), 256'(1));
  endtask

  vec_t tbl [7];

  initial begin
    int t_req, t_first, t_last, t_done, nacc, base, rq, acc0, cyc, nvalid;
    logic [AW-1:0] a_first;
    logic [HW-1:0] h;

    tbl[0] = '{12'h010, 12'h013, 4,    12'h014, 0};
    tbl[1] = '{12'hFFE, 12'h001, 4,    12'h002, 0};
    tbl[2] = '{12'h005, 12'h005, 1,    12'h006, 1};
    tbl[3] = '{12'hFFF, 12'hFFF, 1,    12'h000, 0};
    tbl[4] = '{12'h100, 12'h0FF, 4096, 12'h100, 0};
    tbl[5] = '{12'h000, 12'hFFF, 4096, 12'h000, 1};
    tbl[6] = '{12'h7F0, 12'h80F, 32,   12'h810, 1};

    repeat (3) @(negedge clk);
    chk("reset_outputs", outs, 256'(0));
    rst = 1'b0;
    rd_en = 1'b1;
    repeat (2) @(negedge clk);

    // Timing of a 4-sample event with ready held high
    t_req = -1; t_first = -1; t_last = -1; t_done = -1; nacc = 0; a_first = '0;
    hq.push_back(mk_hdr(12'h010, 12'h013));
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (hdr_rdreq && t_req < 0) begin t_req = c; a_first = wvb_rd_addr; end
      if (dout_valid && dout_ready) begin
        if (t_first < 0) t_first = c;
        t_last = c;
        nacc++;
      end
      if (evt_done && t_done < 0) t_done = c;
    end
    chk("t1_accepts", 256'(nacc), 256'(4 + HDRW));
    chk("t1_done_after_last", 256'(t_done - t_last), 256'(1));
    chk("t1_rd_ptr", 256'(wvb_rd_ptr), 256'(12'h014));
`ifndef WVB_RD_HDR_WORDS_EN
    chk("t1_first_addr", 256'(a_first), 256'(12'h010));
    chk("t1_first_valid_latency", 256'(t_first - t_req), 256'(2));
    chk("t1_consecutive", 256'(t_last - t_first), 256'(3));
`endif

    // Table-driven events: lengths, wrap, full buffer, pointer update
    foreach (tbl[i]) begin
      ready_mode = tbl[i].mode;
      base = done_count;
      h = mk_hdr(tbl[i].start, tbl[i].stop);
      hq.push_back(h);
      wait_done(base + 1, 20000);
      chk($sformatf("tbl%0d_len", i), 256'(evt_len), 256'(tbl[i].exp_len));
      chk($sformatf("tbl%0d_ptr", i), 256'(wvb_rd_ptr), 256'(tbl[i].exp_ptr));
      chk($sformatf("tbl%0d_hdr", i),
          {evt_ltc, evt_start, evt_stop, evt_trig_src, evt_cnst_run, evt_pre_conf}, h);
      repeat (2) @(negedge clk);
    end

    // 64 samples under random backpressure
    ready_mode = 1;
    base = done_count; acc0 = acc_count;
    rnd = $urandom;
    hq.push_back(mk_hdr(rnd[11:0], rnd[11:0] + 12'd63));
    wait_done(base + 1, 2000);
    chk("t3_accepts", 256'(acc_count - acc0), 256'(64 + HDRW));

    // rd_en dropped during event 1 keeps header 2 queued
    ready_mode = 0;
    repeat (3) @(negedge clk);
    base = done_count; rq = rdreq_count;
    hq.push_back(mk_hdr(12'h200, 12'h209));
    hq.push_back(mk_hdr(12'h300, 12'h304));
    cyc = 0;
    while (rdreq_count == rq && cyc < 50) begin @(negedge clk); cyc++; end
    rd_en = 1'b0;
    wait_done(base + 1, 200);
    repeat (10) @(negedge clk);
    chk("t4_no_pop_when_disabled", 256'(rdreq_count), 256'(rq + 1));
    chk("t4_hdr2_queued", 256'(hq.size()), 256'(1));
    rd_en = 1'b1;
    wait_done(base + 2, 200);
    chk("t4_second_pop", 256'(rdreq_count), 256'(rq + 2));

    // Random back-to-back events
    base = done_count;
    for (int k = 0; k < 15; k++) begin
      rnd = $urandom;
      hq.push_back(mk_hdr(rnd[11:0], rnd[11:0] + 12'($urandom_range(0, 79))));
    end
    ready_mode = 1;
    wait_done(base + 15, 20000);
    ready_mode = 0;

    // Reset while word 3 of 8 is presented
    repeat (3) @(negedge clk);
    hq.push_back(mk_hdr(12'h400, 12'h407));
    nacc = 0; cyc = 0;
    while (nacc < 3 && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (dout_valid && dout_ready) nacc++;
    end
    #2 rst = 1'b1;
    #1 chk("t5_async_reset_outputs", outs, 256'(0));
    exp_q.delete();
    exp_evt.delete();
    busy = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    nvalid = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (dout_valid || hdr_rdreq) nvalid++;
    end
    chk("t5_idle_after_reset", 256'(nvalid), 256'(0));
    base = done_count;
    hq.push_back(mk_hdr(12'h020, 12'h025));
    wait_done(base + 1, 200);
    chk("t5_post_reset_ptr", 256'(wvb_rd_ptr), 256'(12'h026));

`ifdef WVB_RD_HDR_WORDS_EN
    // Header words then a single sample
    repeat (2) @(negedge clk);
    base = done_count; acc0 = acc_count;
    hq.push_back({48'h123456789ABC, 12'd5, 12'd5, 8'hA5});
    wait_done(base + 1, 200);
    chk("t6_accepts", 256'(acc_count - acc0), 256'(5));
    chk("t6_len", 256'(evt_len), 256'(1));
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
